// File: rtl/power_iter_pkg.sv
// Shared types for the iterative power unit: FSM state encoding.
package power_iter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/power_iter_mul.sv
// Combinational OUT_W x IN_W multiplier shared by every iteration of power_iter.
module power_iter_mul #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 24
) (
    input  logic [OUT_W-1:0] acc,
    input  logic [IN_W-1:0]  base,
    output logic [OUT_W-1:0] prod,
    output logic             hi_nz
);

    logic [OUT_W+IN_W-1:0] full_s;

    // Full-width product; anything above OUT_W flags overflow.
    always_comb begin
        full_s = {{IN_W{1'b0}}, acc} * {{OUT_W{1'b0}}, base};
        prod   = full_s[OUT_W-1:0];
        hi_nz  = |full_s[OUT_W+IN_W-1:OUT_W];
    end

endmodule

// File: rtl/power_iter.sv
// Iterative unsigned power unit: out_data = in_data ** in_exp using one shared
// multiplier, one multiply per cycle, with wrap or saturate on overflow.
module power_iter
    import power_iter_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int EXP_W = 3,
    parameter int OUT_W = 24,
    parameter int SAT   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    output logic             busy
);

    localparam logic [EXP_W-1:0] CNT_ZERO = {EXP_W{1'b0}};
    localparam logic [EXP_W-1:0] CNT_ONE  = EXP_W'(1);
    localparam logic [OUT_W-1:0] ACC_ONE  = OUT_W'(1);
    localparam logic [OUT_W-1:0] ACC_ONES = {OUT_W{1'b1}};
    localparam logic [OUT_W-1:0] ACC_ZERO = {OUT_W{1'b0}};
    localparam logic [IN_W-1:0]  BASE_ZERO = {IN_W{1'b0}};

    state_e            state_q, state_d;
    logic [OUT_W-1:0]  acc_q, acc_d;
    logic [IN_W-1:0]   base_q, base_d;
    logic [EXP_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    logic [OUT_W-1:0]  prod_s;
    logic              hi_nz_s;
    logic              accept_s;

    power_iter_mul #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_mul (
        .acc   (acc_q),
        .base  (base_q),
        .prod  (prod_s),
        .hi_nz (hi_nz_s)
    );

    assign accept_s = (state_q == IDLE) && in_valid;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = (in_exp == CNT_ZERO) ? DONE : MULT;
                end else begin
                    state_d = IDLE;
                end
            end
            MULT: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = DONE;
                end else begin
                    state_d = MULT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers: accumulator, latched base, remaining count, sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= ACC_ONE;
            base_q <= BASE_ZERO;
            cnt_q  <= CNT_ZERO;
            ovf_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            base_q <= base_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    // Datapath next-state: operands only load on accept, so input changes mid-flight are ignored.
    always_comb begin
        acc_d  = acc_q;
        base_d = base_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    acc_d  = ACC_ONE;
                    base_d = in_data;
                    cnt_d  = in_exp;
                    ovf_d  = 1'b0;
                end else begin
                    acc_d  = acc_q;
                end
            end
            MULT: begin
                acc_d = prod_s;
                ovf_d = ovf_q | hi_nz_s;
                cnt_d = cnt_q - CNT_ONE;
            end
            DONE: begin
                acc_d = acc_q;
            end
            default: begin
                acc_d = acc_q;
            end
        endcase
    end

    // FSM outputs; rst forces the idle-style values immediately.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        out_data  = ACC_ZERO;
        out_ovf   = 1'b0;
        if (rst) begin
            in_ready = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready = 1'b1;
                end
                MULT: begin
                    busy = 1'b1;
                end
                DONE: begin
                    busy      = 1'b1;
                    out_valid = 1'b1;
                    out_ovf   = ovf_q;
                    if ((SAT != 0) && ovf_q) begin
                        out_data = ACC_ONES;
                    end else begin
                        out_data = acc_q;
                    end
                end
                default: begin
                    in_ready = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_power_iter.sv
// Scoreboard bench for power_iter: a wrap (SAT=0) and a saturating (SAT=1)
// instance share stimulus; a negedge monitor pops and checks each result.
module tb_power_iter;

    typedef struct {
        logic [23:0] data;
        logic        ovf;
        int          lat;
        int          acc_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic [2:0]  in_exp;
    logic        out_ready;
    logic        ir   [2];
    logic        ov   [2];
    logic [23:0] od   [2];
    logic        oo   [2];
    logic        bz   [2];

    exp_t        q0[$];
    exp_t        q1[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;

    logic        pv [2];
    logic        pr [2];
    logic [23:0] hd [2];
    logic        ho [2];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    power_iter #(.IN_W(8), .EXP_W(3), .OUT_W(24), .SAT(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
        .in_data(in_data), .in_exp(in_exp), .out_valid(ov[0]),
        .out_ready(out_ready), .out_data(od[0]), .out_ovf(oo[0]), .busy(bz[0])
    );

    power_iter #(.IN_W(8), .EXP_W(3), .OUT_W(24), .SAT(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
        .in_data(in_data), .in_exp(in_exp), .out_valid(ov[1]),
        .out_ready(out_ready), .out_data(od[1]), .out_ovf(oo[1]), .busy(bz[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: new results are popped and compared; held results must stay stable.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            if (pv[k] === 1'b1 && pr[k] === 1'b1) begin
                check($sformatf("dut%0d valid_drop_after_hs", k), {31'd0, ov[k]}, 32'd0);
                check($sformatf("dut%0d idle_after_hs", k), {31'd0, ir[k]}, 32'd1);
            end
            if (ov[k] === 1'b1) begin
                check($sformatf("dut%0d in_ready_in_done", k), {31'd0, ir[k]}, 32'd0);
                if (pv[k] !== 1'b1) begin
                    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                        check($sformatf("dut%0d unexpected_result", k), 32'd1, 32'd0);
                    end else begin
                        e = (k == 0) ? q0.pop_front() : q1.pop_front();
                        check($sformatf("dut%0d out_data", k), {8'd0, od[k]}, {8'd0, e.data});
                        check($sformatf("dut%0d out_ovf", k), {31'd0, oo[k]}, {31'd0, e.ovf});
                        check($sformatf("dut%0d latency", k), cyc - e.acc_cyc, e.lat);
                    end
                end else if (pr[k] !== 1'b1) begin
                    check($sformatf("dut%0d hold_data", k), {8'd0, od[k]}, {8'd0, hd[k]});
                    check($sformatf("dut%0d hold_ovf", k), {31'd0, oo[k]}, {31'd0, ho[k]});
                end
            end
            pv[k] = ov[k];
            pr[k] = out_ready;
            hd[k] = od[k];
            ho[k] = oo[k];
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Issue one request; push the expectation for both instances when a result is due.
    task automatic send(input logic [7:0] b, input logic [2:0] e, input logic [23:0] expd,
                        input logic expo, input bit push);
        exp_t x;
        int   t = 0;
        while (!(ir[0] === 1'b1 && ir[1] === 1'b1) && t < 100) begin
            step();
            t++;
        end
        if (t >= 100) check("in_ready_timeout", 32'd0, 32'd1);
        in_valid = 1'b1;
        in_data  = b;
        in_exp   = e;
        if (push) begin
            x.data = expd; x.ovf = expo; x.lat = int'(e) + 1; x.acc_cyc = cyc;
            q0.push_back(x);
            x.data = expo ? 24'hFFFFFF : expd;
            q1.push_back(x);
        end
        step();
        in_valid = 1'b0;
        in_data  = 8'hA5;
        in_exp   = 3'd6;
        check("busy_after_accept0", {31'd0, bz[0]}, 32'd1);
        check("busy_after_accept1", {31'd0, bz[1]}, 32'd1);
    endtask

    task automatic drain();
        int t = 0;
        while ((q0.size() != 0 || q1.size() != 0 || ov[0] === 1'b1) && t < 200) begin
            step();
            t++;
        end
        if (t >= 200) check("drain_timeout", 32'd0, 32'd1);
        step();
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            pv[k] = 1'b0; pr[k] = 1'b0; hd[k] = 24'd0; ho[k] = 1'b0;
        end
        rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; in_exp = 3'd0; out_ready = 1'b1;
        repeat (3) step();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("dut%0d rst_out_data", k), {8'd0, od[k]}, 32'd0);
            check($sformatf("dut%0d rst_out_ovf", k), {31'd0, oo[k]}, 32'd0);
            check($sformatf("dut%0d rst_out_valid", k), {31'd0, ov[k]}, 32'd0);
            check($sformatf("dut%0d rst_busy", k), {31'd0, bz[k]}, 32'd0);
        end
        rst = 1'b0;
        #1;
        check("in_ready_after_rst0", {31'd0, ir[0]}, 32'd1);
        check("in_ready_after_rst1", {31'd0, ir[1]}, 32'd1);

        send(8'd5,   3'd3, 24'd125,     1'b0, 1'b1); drain();
        send(8'd255, 3'd3, 24'hFD02FF,  1'b0, 1'b1); drain();
        send(8'd7,   3'd0, 24'd1,       1'b0, 1'b1); drain();
        send(8'd255, 3'd4, 24'h05FC01,  1'b1, 1'b1); drain();
        send(8'd2,   3'd7, 24'd128,     1'b0, 1'b1); drain();
        send(8'd16,  3'd7, 24'h000000,  1'b1, 1'b1); drain();
        send(8'd0,   3'd0, 24'd1,       1'b0, 1'b1); drain();

        // Back-pressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        send(8'd3, 3'd2, 24'd9, 1'b0, 1'b1);
        for (int t = 0; t < 50 && ov[0] !== 1'b1; t++) step();
        repeat (3) step();
        out_ready = 1'b1;
        drain();

        // Abort 2^7 with rst on its third multiply cycle, then run 2^2.
        send(8'd2, 3'd7, 24'd0, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b1;
        step();
        check("abort_valid0", {31'd0, ov[0]}, 32'd0);
        check("abort_busy0", {31'd0, bz[0]}, 32'd0);
        check("abort_data1", {8'd0, od[1]}, 32'd0);
        rst = 1'b0;
        #1;
        check("in_ready_after_abort", {31'd0, ir[0]}, 32'd1);
        send(8'd2, 3'd2, 24'd4, 1'b0, 1'b1); drain();

        // Base 0 with input noise while multiplying.
        send(8'd0, 3'd5, 24'd0, 1'b0, 1'b1);
        for (int t = 0; t < 3; t++) begin
            in_valid = ~in_valid;
            in_data  = 8'($urandom);
            in_exp   = 3'($urandom);
            step();
        end
        in_valid = 1'b0;
        drain();

        repeat (5) step();
        check("q0_empty", q0.size(), 32'd0);
        check("q1_empty", q1.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
